// File: rtl/modbus_frame_tx.sv
// Modbus RTU response-frame transmitter.
// Builds slave address + PDU + CRC16 (low byte, then high byte) from a latched
// response descriptor, feeds it byte by byte to uart_byte_tx, then holds the
// line silent for the 3.5-character inter-frame gap before going idle.
module modbus_frame_tx #(
   parameter logic [7:0] ADDR       = 8'h01,
   parameter int         CLK_FREQ   = 50000000,
   parameter int         BAUD_RATE  = 115200,
   parameter int         GAP_CYCLES = (CLK_FREQ / BAUD_RATE) * 35
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic        send_req,
   input  logic [1:0]  resp_type,
   input  logic [7:0]  func_code,
   input  logic [15:0] reg_addr,
   input  logic [15:0] reg_data,
   input  logic [7:0]  exc_code,
   output logic        busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        frame_done
);

   localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   state_t            state, state_next;
   logic [1:0]        type_q;
   logic [7:0]        func_q, exc_q;
   logic [15:0]       addr_q, data_q;
   logic [2:0]        idx, idx_next, last_idx;
   logic [15:0]       crc, crc_next;
   logic [GAP_W-1:0]  gap_cnt, gap_next;
   logic [7:0]        cur_byte, tx_data_next;
   logic              tx_start_next, frame_done_next, capture;

   // One CRC16/Modbus byte step: fold the byte into the low half, then 8 shifts
   function automatic logic [15:0] crc16_update(input logic [15:0] crc_in,
                                                input logic [7:0]  data_in);
      logic [15:0] c;
      c = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      return c;
   endfunction

   // A frame_done cycle is still the tail of the old frame, so requests then are dropped
   assign capture = (state == IDLE) && send_req && (resp_type != 2'd3) && !frame_done;
   assign busy    = (state != IDLE);

   // Latch the descriptor at acceptance so it cannot change mid-frame
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         type_q <= 2'd0;
         func_q <= 8'h00;
         exc_q  <= 8'h00;
         addr_q <= 16'h0000;
         data_q <= 16'h0000;
      end else if (capture) begin
         type_q <= resp_type;
         func_q <= func_code;
         exc_q  <= exc_code;
         addr_q <= reg_addr;
         data_q <= reg_data;
      end
   end

   // Select the byte at the current index for the latched frame layout
   always_comb begin
      cur_byte = 8'h00;
      last_idx = 3'd6;
      case (type_q)
         2'd0: begin
            last_idx = 3'd6;
            case (idx)
               3'd0:    cur_byte = ADDR;
               3'd1:    cur_byte = 8'h03;
               3'd2:    cur_byte = 8'h02;
               3'd3:    cur_byte = data_q[15:8];
               3'd4:    cur_byte = data_q[7:0];
               3'd5:    cur_byte = crc[7:0];
               default: cur_byte = crc[15:8];
            endcase
         end
         2'd1: begin
            last_idx = 3'd7;
            case (idx)
               3'd0:    cur_byte = ADDR;
               3'd1:    cur_byte = 8'h06;
               3'd2:    cur_byte = addr_q[15:8];
               3'd3:    cur_byte = addr_q[7:0];
               3'd4:    cur_byte = data_q[15:8];
               3'd5:    cur_byte = data_q[7:0];
               3'd6:    cur_byte = crc[7:0];
               default: cur_byte = crc[15:8];
            endcase
         end
         default: begin
            last_idx = 3'd4;
            case (idx)
               3'd0:    cur_byte = ADDR;
               3'd1:    cur_byte = func_q | 8'h80;
               3'd2:    cur_byte = exc_q;
               3'd3:    cur_byte = crc[7:0];
               default: cur_byte = crc[15:8];
            endcase
         end
      endcase
   end

   // Next-state and registered-output decisions for the frame sequencer
   always_comb begin
      state_next      = state;
      idx_next        = idx;
      crc_next        = crc;
      gap_next        = gap_cnt;
      tx_start_next   = 1'b0;
      tx_data_next    = tx_data;
      frame_done_next = 1'b0;
      case (state)
         IDLE: begin
            if (capture) begin
               state_next = ISSUE;
               idx_next   = 3'd0;
               crc_next   = 16'hFFFF;
            end
         end
         ISSUE: begin
            tx_start_next = 1'b1;
            tx_data_next  = cur_byte;
            if (idx < (last_idx - 3'd1))
               crc_next = crc16_update(crc, cur_byte);
            state_next = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               if (idx == last_idx) begin
                  state_next = GAP;
                  gap_next   = '0;
               end else begin
                  idx_next   = idx + 3'd1;
                  state_next = ISSUE;
               end
            end
         end
         default: begin
            if (gap_cnt == GAP_LAST) begin
               frame_done_next = 1'b1;
               state_next      = IDLE;
            end else begin
               gap_next = gap_cnt + GAP_W'(1);
            end
         end
      endcase
   end

   // State, index, CRC, gap counter and UART-facing outputs
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= 3'd0;
         crc        <= 16'hFFFF;
         gap_cnt    <= '0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         crc        <= crc_next;
         gap_cnt    <= gap_next;
         tx_start   <= tx_start_next;
         tx_data    <= tx_data_next;
         frame_done <= frame_done_next;
      end
   end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Scoreboard bench for modbus_frame_tx: expected bytes are queued when a
// request is issued, a monitor pops them on every tx_start, and a small
// uart_byte_tx stand-in answers each byte with tx_done.
module tb_modbus_frame_tx;

   localparam int GAP      = 40;
   localparam int UART_LAT = 6;

   logic        sys_clk;
   logic        reset_n;
   logic        send_req;
   logic [1:0]  resp_type;
   logic [7:0]  func_code;
   logic [15:0] reg_addr;
   logic [15:0] reg_data;
   logic [7:0]  exc_code;
   logic        busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        tx_done_model;
   logic        tx_done_extra;
   logic        frame_done;

   int tests_run    = 0;
   int tests_failed = 0;
   int exp_frames   = 0;
   int frames_seen  = 0;
   int done_count   = 0;
   int done_edge    = 0;
   int edge_count   = 0;
   int start_count  = 0;
   logic [7:0] exp_q[$];

   assign tx_done = tx_done_model | tx_done_extra;

   modbus_frame_tx #(
      .ADDR       (8'h01),
      .CLK_FREQ   (50000000),
      .BAUD_RATE  (115200),
      .GAP_CYCLES (GAP)
   ) dut (
      .sys_clk    (sys_clk),
      .reset_n    (reset_n),
      .send_req   (send_req),
      .resp_type  (resp_type),
      .func_code  (func_code),
      .reg_addr   (reg_addr),
      .reg_data   (reg_data),
      .exc_code   (exc_code),
      .busy       (busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .frame_done (frame_done)
   );

   // Free-running clock
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Rising-edge counter used to time the inter-frame gap
   initial begin
      forever begin
         @(posedge sys_clk);
         edge_count++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic expectFrame(input logic [63:0] bytes, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(bytes[8*(n-1-i) +: 8]);
      exp_frames++;
   endtask

   task automatic applyStimulus(input logic [1:0] rtype, input logic [7:0] fc,
                                input logic [15:0] ra, input logic [15:0] rd,
                                input logic [7:0] ec, input logic accept,
                                input logic exp_busy, input string name);
      @(negedge sys_clk);
      resp_type = rtype;
      func_code = fc;
      reg_addr  = ra;
      reg_data  = rd;
      exc_code  = ec;
      send_req  = 1'b1;
      @(negedge sys_clk);
      send_req = 1'b0;
      checkOutput({name, " busy after request"}, 32'(busy), 32'(exp_busy));
      if (accept) begin
         checkOutput({name, " no tx_start at capture"}, 32'(tx_start), 32'd0);
         @(negedge sys_clk);
         checkOutput({name, " first tx_start latency"}, 32'(tx_start), 32'd1);
      end
   endtask

   task automatic waitDone(input int target, input string name);
      int n = 0;
      while (done_count < target && n < 500) begin
         @(negedge sys_clk);
         n++;
      end
      if (done_count < target) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s: timeout, tx_done count %0d, required %0d", name, done_count, target);
      end
   endtask

   task automatic waitFrameDone(input string name);
      int n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (frame_done !== 1'b1 && n < 2000);
      if (frame_done !== 1'b1) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s: frame_done timeout, got 0, required 1", name);
      end
   endtask

   // uart_byte_tx stand-in: answers each tx_start with tx_done after a fixed latency
   initial begin
      int uart_cnt;
      logic [7:0] held;
      uart_cnt      = 0;
      held          = 8'h00;
      tx_done_model = 1'b0;
      forever begin
         @(posedge sys_clk);
         #1;
         tx_done_model = 1'b0;
         if (reset_n !== 1'b1) begin
            uart_cnt = 0;
         end else if (tx_start === 1'b1) begin
            uart_cnt = UART_LAT;
            held     = tx_data;
         end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
               checkOutput("tx_data stable until tx_done", 32'(tx_data), 32'(held));
               tx_done_model = 1'b1;
               done_count++;
               done_edge = edge_count + 1;
            end
         end
      end
   end

   // Monitor: pop the scoreboard on every tx_start and time every frame_done
   initial begin
      logic [7:0] exp_b;
      forever begin
         @(negedge sys_clk);
         if (reset_n === 1'b1) begin
            if (tx_start === 1'b1) begin
               start_count++;
               if (exp_q.size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("[TB] FAIL stray tx_start: tx_data %0h, required no byte", tx_data);
               end else begin
                  exp_b = exp_q.pop_front();
                  checkOutput("tx_data byte", 32'(tx_data), 32'(exp_b));
               end
            end
            if (frame_done === 1'b1) begin
               frames_seen++;
               checkOutput("frame_done count", 32'(frames_seen), 32'(exp_frames));
               checkOutput("gap length", 32'(edge_count - done_edge), 32'(GAP + 1));
               checkOutput("bytes left at frame_done", 32'(exp_q.size()), 32'd0);
               checkOutput("busy low with frame_done", 32'(busy), 32'd0);
            end
         end
      end
   end

   // Directed scenario sequence
   initial begin
      int base;
      int s0;
      reset_n       = 1'b0;
      send_req      = 1'b0;
      resp_type     = 2'd0;
      func_code     = 8'h00;
      reg_addr      = 16'h0000;
      reg_data      = 16'h0000;
      exc_code      = 8'h00;
      tx_done_extra = 1'b0;

      repeat (3) @(negedge sys_clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset tx_start", 32'(tx_start), 32'd0);
      checkOutput("reset tx_data", 32'(tx_data), 32'd0);
      checkOutput("reset frame_done", 32'(frame_done), 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge sys_clk);

      // Reserved response type and a stray tx_done must both leave it idle
      applyStimulus(2'd3, 8'h03, 16'h0000, 16'h0001, 8'h00, 1'b0, 1'b0, "reserved");
      @(negedge sys_clk);
      tx_done_extra = 1'b1;
      @(negedge sys_clk);
      tx_done_extra = 1'b0;
      repeat (20) @(negedge sys_clk);
      checkOutput("reserved busy", 32'(busy), 32'd0);
      checkOutput("reserved tx_start count", 32'(start_count), 32'd0);

      // Read response, with a request and a stray tx_done during the gap
      base = done_count;
      s0   = start_count;
      expectFrame(64'h01030200017984, 7);
      applyStimulus(2'd0, 8'h03, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1, "read");
      waitDone(base + 7, "read bytes");
      repeat (3) @(negedge sys_clk);
      applyStimulus(2'd0, 8'h03, 16'h0000, 16'h00FF, 8'h00, 1'b0, 1'b1, "request during gap");
      tx_done_extra = 1'b1;
      @(negedge sys_clk);
      tx_done_extra = 1'b0;
      waitFrameDone("read");
      checkOutput("read tx_start count", 32'(start_count - s0), 32'd7);

      // Write echo, then a request coincident with its frame_done
      expectFrame(64'h0106000100051809, 8);
      applyStimulus(2'd1, 8'h06, 16'h0001, 16'h0005, 8'h00, 1'b1, 1'b1, "echo");
      waitFrameDone("echo");
      resp_type = 2'd2;
      func_code = 8'h03;
      exc_code  = 8'h02;
      send_req  = 1'b1;
      @(negedge sys_clk);
      send_req = 1'b0;
      repeat (10) @(negedge sys_clk);
      checkOutput("coincident request busy", 32'(busy), 32'd0);

      // Exception response
      expectFrame(64'h018302C0F1, 5);
      applyStimulus(2'd2, 8'h03, 16'h1234, 16'h5678, 8'h02, 1'b1, 1'b1, "exception");
      waitFrameDone("exception");

      // Reset after the third byte completes abandons the frame
      base = done_count;
      expectFrame(64'h01030200017984, 7);
      applyStimulus(2'd0, 8'h03, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1, "aborted read");
      waitDone(base + 3, "aborted read bytes");
      @(posedge sys_clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid-frame reset busy", 32'(busy), 32'd0);
      checkOutput("mid-frame reset tx_start", 32'(tx_start), 32'd0);
      checkOutput("mid-frame reset tx_data", 32'(tx_data), 32'd0);
      checkOutput("mid-frame reset frame_done", 32'(frame_done), 32'd0);
      exp_q.delete();
      exp_frames--;
      repeat (4) @(negedge sys_clk);
      s0      = start_count;
      reset_n = 1'b1;
      repeat (30) @(negedge sys_clk);
      checkOutput("no tx_start after reset", 32'(start_count - s0), 32'd0);
      checkOutput("idle after reset release", 32'(busy), 32'd0);

      // Fresh read after reset
      s0 = start_count;
      expectFrame(64'h01030200017984, 7);
      applyStimulus(2'd0, 8'h03, 16'h0000, 16'h0001, 8'h00, 1'b1, 1'b1, "read after reset");
      waitFrameDone("read after reset");
      checkOutput("read after reset tx_start count", 32'(start_count - s0), 32'd7);
      repeat (5) @(negedge sys_clk);
      checkOutput("frames completed", 32'(frames_seen), 32'd4);
      checkOutput("leftover expected bytes", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
